apb_bridge_fsm: RTL and testbench
=================================

// Module: apb_bridge_fsm
// PURPOSE
//  AHB-to-APB bridge control FSM. Sits behind the AHB slave pipeline registers, which supply
//  the Haddr1/Haddr2/Hwdata1/Hwdata2/Hwritereg/tempselx inputs. Turns validated AHB transfers
//  into two-phase APB transfers (SETUP then ENABLE), stalls AHB through Hreadyout, and
//  supports back-to-back pipelined writes.
// PARAMETERS
//  AW   32  address width (Haddr*, Paddr)
//  DW   32  data width (Hwdata*, Pwdata, Prdata)
//  NSEL 3   number of APB slave selects (tempselx, Pselx)
// PORTS
//  Hclk       in   1     clock; all logic on posedge
//  Hresetn    in   1     reset: synchronous, active-high (1 = reset), despite the legacy name
//  Hwrite     in   1     current AHB direction (1 = write)
//  valid      in   1     current AHB transfer is a valid bridge access
//  Hwritereg  in   1     Hwrite delayed one cycle
//  Haddr      in   AW    current AHB address
//  Hwdata     in   DW    current AHB write data
//  Haddr1     in   AW    Haddr delayed 1 cycle
//  Haddr2     in   AW    Haddr delayed 2 cycles
//  Hwdata1    in   DW    Hwdata delayed 1 cycle
//  Hwdata2    in   DW    Hwdata delayed 2 cycles (unused; port kept for pipeline symmetry)
//  tempselx   in   NSEL  decoded one-hot slave select
//  Pwrite     out  1     APB direction
//  Penable    out  1     APB enable (access phase)
//  Hreadyout  out  1     AHB ready; 0 = stall
//  Pselx      out  NSEL  APB slave select
//  Pwdata     out  DW    APB write data
//  Paddr      out  AW    APB address
//  Prdata     out  DW    read data returned to AHB
// BEHAVIOUR
//  - All outputs are registered. Reset sets state=IDLE, Hreadyout=1, and every other output to 0.
//  - States: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP.
//  - Transitions:
//    IDLE/RENABLE/WENABLE: valid&~Hwrite->READ; valid&Hwrite->WWAIT; otherwise IDLE.
//    READ->RENABLE.  WRITEP->WENABLEP.
//    WWAIT: valid->WRITEP, else WRITE.
//    WRITE: valid->WENABLEP, else WENABLE.
//    WENABLEP: ~Hwritereg->READ; Hwritereg&valid->WRITEP; Hwritereg&~valid->WRITE.
//  - Outputs are loaded on the transition edge. Anything not listed holds its value.
//    enter READ from IDLE/RENABLE/WENABLE: Paddr=Haddr, Pwrite=0, Pselx=tempselx,
//      Penable=0, Hreadyout=0.
//    enter READ from WENABLEP: Paddr=Haddr2, Pwrite=0, Pselx=tempselx, Penable=0,
//      Hreadyout=0.
//    enter WRITE/WRITEP from WWAIT: Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1,
//      Pselx=tempselx, Penable=0, Hreadyout=0.
//    enter WRITE/WRITEP from WENABLEP: Paddr=Haddr2, Pwdata=Hwdata1, Pwrite=1,
//      Pselx=tempselx, Penable=0, Hreadyout=0.
//    enter RENABLE/WENABLE/WENABLEP: Penable=1, Hreadyout=1.
//    enter IDLE or WWAIT: Penable=0, Pselx=0, Hreadyout=1.
//  - Latency: a read takes 2 cycles (SETUP+ENABLE) from IDLE. A single write takes 3
//    (WWAIT+SETUP+ENABLE). Consecutive writes take 2 each after the first.
//  - Pselx is only ever tempselx or 0. Penable is only 1 in the *ENABLE states.
//  - Reset asserted mid-transfer aborts the transfer on the next edge and restores the reset
//    values. No partial APB cycle continues.
//  - valid and Hwrite at X or changing mid-cycle: only the posedge-sampled value matters.
// CONFIGURATION
//  APB_READ_STUB_EN defined: in RENABLE, Prdata registers Paddr (address-echo stub for
//    standalone tests); it holds in all other states.
//  APB_READ_STUB_EN undefined: Prdata is tied to 0.
// TESTING
//  1 Reset: Hresetn=1 for one edge -> state IDLE, Hreadyout=1, Penable=0, Pselx=0,
//    Paddr=0, Pwrite=0.
//  2 Single read: valid=1, Hwrite=0, Haddr=32'h8040_0000, tempselx=3'b010
//    -> next edge: Paddr=8040_0000, Pselx=010, Penable=0, Hreadyout=0.
//    -> following edge: Penable=1, Hreadyout=1.
//    -> with the stub enabled, Prdata=8040_0000.
//  3 Single write: valid=1, Hwrite=1 for one cycle, then valid=0; Haddr1=32'h8c00_1234,
//    Hwdata=32'h8500_0000, tempselx=001 -> WWAIT -> WRITE (Paddr=8c00_1234,
//    Pwdata=8500_0000, Pwrite=1, Pselx=001) -> WENABLE (Penable=1) -> IDLE (Pselx=0).
//  4 Back-to-back writes: valid=1, Hwrite=1 held, Hwritereg=1, Haddr2=32'h9000_1111,
//    Hwdata1=32'h9500_0000 -> WWAIT, WRITEP, WENABLEP, WRITEP (Paddr=9000_1111,
//    Pwdata=9500_0000), WENABLEP; Hreadyout toggles 0/1 each cycle.
//  5 Write then read: in WENABLEP with Hwritereg=0 -> READ with Paddr=Haddr2, Pwrite=0.
//  6 Reset mid-read: assert Hresetn while in READ -> next edge IDLE, Penable=0, Pselx=0,
//    Hreadyout=1.

Source files
------------

// File: rtl/apb_bridge_fsm.sv
// AHB-to-APB bridge control FSM: two-phase APB transfers with pipelined writes.
// Optional APB_READ_STUB_EN: Prdata echoes Paddr in RENABLE instead of reading 0.
module apb_bridge_fsm #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NSEL = 3
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  input  logic            Hwrite,
  input  logic            valid,
  input  logic            Hwritereg,
  input  logic [AW-1:0]   Haddr,
  input  logic [DW-1:0]   Hwdata,
  input  logic [AW-1:0]   Haddr1,
  input  logic [AW-1:0]   Haddr2,
  input  logic [DW-1:0]   Hwdata1,
  input  logic [DW-1:0]   Hwdata2,
  input  logic [NSEL-1:0] tempselx,
  output logic            Pwrite,
  output logic            Penable,
  output logic            Hreadyout,
  output logic [NSEL-1:0] Pselx,
  output logic [DW-1:0]   Pwdata,
  output logic [AW-1:0]   Paddr,
  output logic [DW-1:0]   Prdata
);

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, WRITE,
    WRITEP, RENABLE, WENABLE, WENABLEP
  } state_t;

  state_t          state, nstate;
  logic            n_pwrite, n_penable, n_hready;
  logic [NSEL-1:0] n_pselx;
  logic [DW-1:0]   n_pwdata;
  logic [AW-1:0]   n_paddr;

  // Hwdata2 exists only for pipeline symmetry.
  logic unused_hwdata2;
  assign unused_hwdata2 = ^Hwdata2;

  always_ff @(posedge Hclk) begin
    if (Hresetn) begin
      state     <= IDLE;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Hreadyout <= 1'b1;
      Pselx     <= '0;
      Pwdata    <= '0;
      Paddr     <= '0;
    end else begin
      state     <= nstate;
      Pwrite    <= n_pwrite;
      Penable   <= n_penable;
      Hreadyout <= n_hready;
      Pselx     <= n_pselx;
      Pwdata    <= n_pwdata;
      Paddr     <= n_paddr;
    end
  end

  always_comb begin
    nstate    = state;
    n_pwrite  = Pwrite;
    n_penable = Penable;
    n_hready  = Hreadyout;
    n_pselx   = Pselx;
    n_pwdata  = Pwdata;
    n_paddr   = Paddr;
    case (state)
      IDLE, RENABLE, WENABLE: begin
        if (valid && !Hwrite) begin
          nstate    = READ;
          n_paddr   = Haddr;
          n_pwrite  = 1'b0;
          n_pselx   = tempselx;
          n_penable = 1'b0;
          n_hready  = 1'b0;
        end else begin
          nstate    = valid ? WWAIT : IDLE;
          n_penable = 1'b0;
          n_pselx   = '0;
          n_hready  = 1'b1;
        end
      end
      READ, WRITE, WRITEP: begin
        n_penable = 1'b1;
        n_hready  = 1'b1;
        case (state)
          READ:    nstate = RENABLE;
          WRITE:   nstate = valid ? WENABLEP : WENABLE;
          default: nstate = WENABLEP;
        endcase
      end
      WWAIT: begin
        nstate    = valid ? WRITEP : WRITE;
        n_paddr   = Haddr1;
        n_pwdata  = Hwdata;
        n_pwrite  = 1'b1;
        n_pselx   = tempselx;
        n_penable = 1'b0;
        n_hready  = 1'b0;
      end
      WENABLEP: begin
        // Pipelined exit: the next transfer's address is two stages back.
        n_paddr   = Haddr2;
        n_pselx   = tempselx;
        n_penable = 1'b0;
        n_hready  = 1'b0;
        if (!Hwritereg) begin
          nstate   = READ;
          n_pwrite = 1'b0;
        end else begin
          nstate   = valid ? WRITEP : WRITE;
          n_pwdata = Hwdata1;
          n_pwrite = 1'b1;
        end
      end
      default: begin
        nstate    = IDLE;
        n_penable = 1'b0;
        n_pselx   = '0;
        n_hready  = 1'b1;
      end
    endcase
  end

`ifdef APB_READ_STUB_EN
  always_ff @(posedge Hclk) begin
    if (Hresetn)
      Prdata <= '0;
    else if (state == RENABLE)
      Prdata <= Paddr;
  end
`else
  assign Prdata = '0;
`endif

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// Directed bench for apb_bridge_fsm: reset, read, write, pipelined writes, abort.
// Prdata expectations follow APB_READ_STUB_EN when the bench is built with it.
module tb_apb_bridge_fsm;

  logic        Hclk = 1'b0;
  logic        Hresetn, Hwrite, valid, Hwritereg;
  logic [31:0] Haddr, Hwdata, Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic [2:0]  tempselx;
  logic        Pwrite, Penable, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Pwdata, Paddr, Prdata;

  int errors = 0;
  int checks = 0;

  apb_bridge_fsm dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite),
    .valid(valid), .Hwritereg(Hwritereg),
    .Haddr(Haddr), .Hwdata(Hwdata),
    .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
    .tempselx(tempselx), .Pwrite(Pwrite),
    .Penable(Penable), .Hreadyout(Hreadyout),
    .Pselx(Pselx), .Pwdata(Pwdata),
    .Paddr(Paddr), .Prdata(Prdata)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  logic [31:0] rd_exp;

  initial begin
    Hresetn = 1'b1; Hwrite = 1'b0; valid = 1'b0;
    Hwritereg = 1'b0; Haddr = '0; Hwdata = '0;
    Haddr1 = '0; Haddr2 = '0; Hwdata1 = '0;
    Hwdata2 = '0; tempselx = '0;

    // reset
    step();
    chk("rst_hready", 32'(Hreadyout), 32'd1);
    chk("rst_penable", 32'(Penable), 32'd0);
    chk("rst_pselx", 32'(Pselx), 32'd0);
    chk("rst_paddr", Paddr, 32'd0);
    chk("rst_pwrite", 32'(Pwrite), 32'd0);
    chk("rst_pwdata", Pwdata, 32'd0);
    chk("rst_prdata", Prdata, 32'd0);
    Hresetn = 1'b0;

    // single read
    valid = 1'b1; Hwrite = 1'b0;
    Haddr = 32'h8040_0000; tempselx = 3'b010;
    step();
    chk("rd_paddr", Paddr, 32'h8040_0000);
    chk("rd_pselx", 32'(Pselx), 32'd2);
    chk("rd_penable", 32'(Penable), 32'd0);
    chk("rd_hready", 32'(Hreadyout), 32'd0);
    chk("rd_pwrite", 32'(Pwrite), 32'd0);
    valid = 1'b0;
    step();
    chk("ren_penable", 32'(Penable), 32'd1);
    chk("ren_hready", 32'(Hreadyout), 32'd1);
    chk("ren_pselx", 32'(Pselx), 32'd2);
    step();
`ifdef APB_READ_STUB_EN
    rd_exp = 32'h8040_0000;
`else
    rd_exp = 32'h0;
`endif
    chk("rd_prdata", Prdata, rd_exp);
    chk("rd_idle_pselx", 32'(Pselx), 32'd0);
    chk("rd_idle_penable", 32'(Penable), 32'd0);

    // single write
    valid = 1'b1; Hwrite = 1'b1; tempselx = 3'b001;
    Haddr = 32'h8c00_1234;
    step();
    chk("ww_hready", 32'(Hreadyout), 32'd1);
    chk("ww_pselx", 32'(Pselx), 32'd0);
    chk("ww_paddr_hold", Paddr, 32'h8040_0000);
    valid = 1'b0; Hwrite = 1'b0;
    Haddr1 = 32'h8c00_1234; Hwdata = 32'h8500_0000;
    step();
    chk("wr_paddr", Paddr, 32'h8c00_1234);
    chk("wr_pwdata", Pwdata, 32'h8500_0000);
    chk("wr_pwrite", 32'(Pwrite), 32'd1);
    chk("wr_pselx", 32'(Pselx), 32'd1);
    chk("wr_hready", 32'(Hreadyout), 32'd0);
    chk("wr_penable", 32'(Penable), 32'd0);
    step();
    chk("wen_penable", 32'(Penable), 32'd1);
    chk("wen_hready", 32'(Hreadyout), 32'd1);
    step();
    chk("w_idle_pselx", 32'(Pselx), 32'd0);
    chk("w_idle_penable", 32'(Penable), 32'd0);
    chk("w_idle_pwrite", 32'(Pwrite), 32'd1);
    chk("w_idle_prdata", Prdata, rd_exp);

    // back-to-back writes
    valid = 1'b1; Hwrite = 1'b1; Hwritereg = 1'b1;
    tempselx = 3'b100;
    Haddr1 = 32'ha000_0001; Hwdata = 32'ha500_0000;
    Haddr2 = 32'h9000_1111; Hwdata1 = 32'h9500_0000;
    step();
    chk("bb_ww_hready", 32'(Hreadyout), 32'd1);
    step();
    chk("bb_wp1_paddr", Paddr, 32'ha000_0001);
    chk("bb_wp1_pwdata", Pwdata, 32'ha500_0000);
    chk("bb_wp1_hready", 32'(Hreadyout), 32'd0);
    chk("bb_wp1_pselx", 32'(Pselx), 32'd4);
    step();
    chk("bb_we1_penable", 32'(Penable), 32'd1);
    chk("bb_we1_hready", 32'(Hreadyout), 32'd1);
    step();
    chk("bb_wp2_paddr", Paddr, 32'h9000_1111);
    chk("bb_wp2_pwdata", Pwdata, 32'h9500_0000);
    chk("bb_wp2_hready", 32'(Hreadyout), 32'd0);
    chk("bb_wp2_penable", 32'(Penable), 32'd0);
    step();
    chk("bb_we2_hready", 32'(Hreadyout), 32'd1);
    chk("bb_we2_penable", 32'(Penable), 32'd1);

    // write then read from WENABLEP
    Hwritereg = 1'b0; Hwrite = 1'b0;
    Haddr2 = 32'h7700_0040; tempselx = 3'b010;
    step();
    chk("wr2rd_paddr", Paddr, 32'h7700_0040);
    chk("wr2rd_pwrite", 32'(Pwrite), 32'd0);
    chk("wr2rd_pselx", 32'(Pselx), 32'd2);
    chk("wr2rd_hready", 32'(Hreadyout), 32'd0);
    chk("wr2rd_penable", 32'(Penable), 32'd0);

    // reset while in READ
    Hresetn = 1'b1; valid = 1'b0;
    step();
    chk("abort_penable", 32'(Penable), 32'd0);
    chk("abort_pselx", 32'(Pselx), 32'd0);
    chk("abort_hready", 32'(Hreadyout), 32'd1);
    chk("abort_paddr", Paddr, 32'd0);
    chk("abort_prdata", Prdata, 32'd0);
    Hresetn = 1'b0;
    step();
    chk("post_idle_penable", 32'(Penable), 32'd0);
    chk("post_idle_hready", 32'(Hreadyout), 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
